// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared constants and types for the destination-register scoreboard.
package reg_dest_scoreboard_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned CNT_W    = 2;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;
  localparam cnt_t      CNT_MAX  = '1;
  localparam cnt_t      CNT_ONE  = cnt_t'(1);

endpackage

// File: rtl/reg_dest_scoreboard_if.sv
// Issue/retire/lookup signal bundle between decode/write-back logic and the scoreboard.
interface reg_dest_scoreboard_if;
  import reg_dest_scoreboard_pkg::*;

  logic                issue_valid;
  reg_addr_t           issue_dest;
  logic                issue_ready;
  logic                retire_valid;
  reg_addr_t           retire_dest;
  reg_addr_t           src_a;
  reg_addr_t           src_b;
  logic                busy_a;
  logic                busy_b;
  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;
  logic                underflow_err;

  modport master (
    output issue_valid, issue_dest, retire_valid, retire_dest, src_a, src_b,
    input  issue_ready, busy_a, busy_b, stall, busy_vec, underflow_err
  );

  modport slave (
    input  issue_valid, issue_dest, retire_valid, retire_dest, src_a, src_b,
    output issue_ready, busy_a, busy_b, stall, busy_vec, underflow_err
  );

endinterface

// File: rtl/reg_dest_scoreboard_dest_decoder.sv
// Register-number to one-hot decoder with enable; bit 0 (hardwired zero register) never asserts.
module dest_decoder #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    onehot[0] = 1'b0;
  end

endmodule

// File: rtl/reg_dest_scoreboard.sv
// Destination-register scoreboard: per-register pending-write counters driving decode stall.
// Optional SCOREBOARD_BYPASS_EN: same-cycle retire of a last pending write clears its busy bit.
module reg_dest_scoreboard
  import reg_dest_scoreboard_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  reg_dest_scoreboard_if.slave sb
);

  cnt_t                cnt_q [NUM_REGS];
  cnt_t                cnt_d [NUM_REGS];
  logic                err_q;
  logic                err_d;

  logic [NUM_REGS-1:0] issue_hit;
  logic [NUM_REGS-1:0] retire_hit;
  logic [NUM_REGS-1:0] nz_vec;
  logic [NUM_REGS-1:0] underflow_vec;
  logic [NUM_REGS-1:0] busy_int;
  logic                retire_match;
  logic                issue_ready;
  logic                issue_acc;

  // A retire to the same register frees a slot in the same cycle, so a full counter still accepts.
  assign retire_match = sb.retire_valid & (sb.retire_dest == sb.issue_dest);
  assign issue_ready  = (cnt_q[sb.issue_dest] != CNT_MAX) | retire_match;
  assign issue_acc    = sb.issue_valid & issue_ready;

  dest_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_issue_dec (
    .en     (issue_acc),
    .addr   (sb.issue_dest),
    .onehot (issue_hit)
  );

  dest_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_retire_dec (
    .en     (sb.retire_valid),
    .addr   (sb.retire_dest),
    .onehot (retire_hit)
  );

  always_comb begin
    underflow_vec = '0;
    nz_vec        = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d[i]         = cnt_q[i];
      nz_vec[i]        = (cnt_q[i] != '0);
      underflow_vec[i] = retire_hit[i] & ~nz_vec[i];
      // Retire only decrements a nonzero count; an issue on top of an underflowing retire lands as +1.
      case ({issue_hit[i], retire_hit[i] & nz_vec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    cnt_d[0] = '0;
    err_d    = err_q | (|underflow_vec);
  end

`ifdef SCOREBOARD_BYPASS_EN
  logic [NUM_REGS-1:0] bypass_vec;

  always_comb begin
    bypass_vec = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      bypass_vec[i] = retire_hit[i] & (cnt_q[i] == CNT_ONE);
    end
    busy_int = nz_vec & ~bypass_vec;
  end
`else
  always_comb begin
    busy_int = nz_vec;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign sb.issue_ready   = issue_ready;
  assign sb.busy_vec      = busy_int;
  assign sb.busy_a        = busy_int[sb.src_a];
  assign sb.busy_b        = busy_int[sb.src_b];
  assign sb.stall         = busy_int[sb.src_a] | busy_int[sb.src_b];
  assign sb.underflow_err = err_q;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Self-checking bench for reg_dest_scoreboard: directed scenarios then randomized traffic vs. a count model.
module tb_reg_dest_scoreboard;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int   mcnt [32];
  bit   merr;

  reg_dest_scoreboard_if sb_if ();

  reg_dest_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int r);
    bit b;
    b = (r != 0) && (mcnt[r] > 0);
`ifdef SCOREBOARD_BYPASS_EN
    if (sb_if.retire_valid && int'(sb_if.retire_dest) == r && mcnt[r] == 1) b = 0;
`endif
    return b;
  endfunction

  function automatic bit m_ready();
    int d = int'(sb_if.issue_dest);
    return (d == 0) || (mcnt[d] < 3) ||
           (sb_if.retire_valid && sb_if.retire_dest == sb_if.issue_dest);
  endfunction

  task automatic m_clear();
    foreach (mcnt[i]) mcnt[i] = 0;
    merr = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] bv;
    bit ba, bb;
    for (int r = 0; r < 32; r++) bv[r] = m_busy(r);
    ba = m_busy(int'(sb_if.src_a));
    bb = m_busy(int'(sb_if.src_b));
    chk({tag, ".busy_vec"}, sb_if.busy_vec, bv);
    chk({tag, ".busy_a"}, 32'(sb_if.busy_a), 32'(ba));
    chk({tag, ".busy_b"}, 32'(sb_if.busy_b), 32'(bb));
    chk({tag, ".stall"}, 32'(sb_if.stall), 32'(ba | bb));
    chk({tag, ".issue_ready"}, 32'(sb_if.issue_ready), 32'(m_ready()));
    chk({tag, ".underflow_err"}, 32'(sb_if.underflow_err), 32'(merr));
  endtask

  // Called at posedge+1: drive, settle, check against model, then advance model across the edge.
  task automatic step(input string tag, input bit iv, input int id, input bit rv, input int rd,
                      input int sa, input int sb);
    bit acc;
    sb_if.issue_valid  = iv;
    sb_if.issue_dest   = 5'(id);
    sb_if.retire_valid = rv;
    sb_if.retire_dest  = 5'(rd);
    sb_if.src_a        = 5'(sa);
    sb_if.src_b        = 5'(sb);
    #2;
    check_all(tag);
    acc = iv && m_ready() && id != 0;
    @(posedge clk);
    if (rv && rd != 0) begin
      if (mcnt[rd] == 0) merr = 1;
      else mcnt[rd] = mcnt[rd] - 1;
    end
    if (acc) mcnt[id] = mcnt[id] + 1;
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    sb_if.issue_valid  = 1'b0;
    sb_if.retire_valid = 1'b0;
    sb_if.src_a        = 5'd5;
    sb_if.src_b        = 5'd3;
    #1;
    rst_n = 1'b0;
    #1;
    m_clear();
    chk({tag, ".busy_vec"}, sb_if.busy_vec, 32'h0);
    chk({tag, ".stall"}, 32'(sb_if.stall), 32'h0);
    chk({tag, ".issue_ready"}, 32'(sb_if.issue_ready), 32'h1);
    chk({tag, ".underflow_err"}, 32'(sb_if.underflow_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_clear();
    rst_n = 1'b0;
    sb_if.issue_valid  = 1'b0;
    sb_if.issue_dest   = '0;
    sb_if.retire_valid = 1'b0;
    sb_if.retire_dest  = '0;
    sb_if.src_a        = '0;
    sb_if.src_b        = '0;
    repeat (2) @(posedge clk);
    #1;
    sb_if.issue_dest = 5'd9;
    #1;
    chk("rst.busy_vec", sb_if.busy_vec, 32'h0);
    chk("rst.issue_ready", 32'(sb_if.issue_ready), 32'h1);
    chk("rst.err", 32'(sb_if.underflow_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Issue 8, then read it as src_a, then retire it.
    step("t2.issue", 1, 8, 0, 0, 0, 0);
    step("t2.busy", 0, 0, 0, 0, 8, 1);
    chk("t2.busy_a_const", 32'(sb_if.busy_a), 32'h1);
    step("t2.retire", 0, 0, 1, 8, 8, 1);
    step("t2.after", 0, 0, 0, 0, 8, 1);
    chk("t2.busy_a_clear", 32'(sb_if.busy_a), 32'h0);

    // Saturate register 5, then issue with same-cycle retire.
    step("t3.i1", 1, 5, 0, 0, 5, 0);
    step("t3.i2", 1, 5, 0, 0, 5, 0);
    step("t3.i3", 1, 5, 0, 0, 5, 0);
    step("t3.full", 1, 5, 0, 0, 5, 0);
    chk("t3.ready_low", 32'(sb_if.issue_ready), 32'h0);
    step("t3.i4_ret", 1, 5, 1, 5, 5, 0);
    step("t3.still_full", 1, 5, 0, 0, 5, 0);
    chk("t3.ready_still_low", 32'(sb_if.issue_ready), 32'h0);

    // Register 0 never changes state.
    step("t4.zero", 1, 0, 1, 0, 0, 0);
    step("t4.after", 0, 0, 0, 0, 0, 0);

    // Underflow on 12 is sticky.
    step("t5.under", 0, 0, 1, 12, 12, 0);
    step("t5.sticky1", 0, 0, 0, 0, 12, 0);
    chk("t5.err_set", 32'(sb_if.underflow_err), 32'h1);
    step("t5.sticky2", 0, 0, 0, 0, 12, 0);

    // Independent issue/retire on different registers.
    step("t6.pre", 1, 7, 0, 0, 3, 7);
    step("t6.both", 1, 3, 1, 7, 3, 7);
    step("t6.after", 0, 0, 0, 0, 3, 7);
    chk("t6.bit3", 32'(sb_if.busy_vec[3]), 32'h1);
    chk("t6.bit7", 32'(sb_if.busy_vec[7]), 32'h0);

    // Async reset with counters nonzero and err set.
    async_reset_check("t1.reset");
    step("t1.post", 0, 5, 0, 0, 5, 3);

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        async_reset_check("rnd.reset");
      end else begin
        step("rnd", ($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
             ($urandom_range(0, 9) < 5), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
